// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues instruction-memory requests and presents
// fetched words to decode through an output slot backed by a one-entry skid slot.
module fetch_ctrl #(
   parameter int unsigned           data_width = 32,
   parameter logic [data_width-1:0] RESET_PC   = '0
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  imem_req,
   output logic [data_width-1:0] imem_addr,
   input  logic                  imem_ack,
   input  logic [data_width-1:0] imem_rdata,
   input  logic                  stall,
   input  logic                  redirect,
   input  logic [data_width-1:0] redirect_pc,
   output logic [data_width-1:0] instr_reg_fetch,
   output logic [data_width-1:0] pc_fetch,
   output logic [data_width-1:0] npc_fetch,
   output logic                  fetch_valid,
   output logic [1:0]            state_dbg
);

   // Debug state code: 0 = IDLE, 1 = FETCH, 2 = KILL.
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_FETCH = 2'd1, S_KILL = 2'd2} state_t;

   localparam logic [data_width-1:0] FOUR = data_width'(4);

   state_t                state_q, state_d;
   logic [data_width-1:0] pc_q, pc_d;
   logic [data_width-1:0] addr_q, addr_d;
   logic [data_width-1:0] oinstr_q, oinstr_d, opc_q, opc_d, onpc_q, onpc_d;
   logic                  ovalid_q, ovalid_d;
   logic [data_width-1:0] sinstr_q, sinstr_d, spc_q, spc_d;
   logic                  svalid_q, svalid_d;
   logic                  req, ack_acc, consume;
   logic [data_width-1:0] redirect_tgt;

   assign redirect_tgt = {redirect_pc[data_width-1:2], 2'b00};
   // KILL keeps the abandoned request up until its ack so the bus protocol holds.
   assign req          = ((state_q == S_FETCH) && !svalid_q) || (state_q == S_KILL);
   assign ack_acc      = req && imem_ack;
   assign consume      = ovalid_q && !stall;

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      oinstr_d = oinstr_q;
      opc_d    = opc_q;
      onpc_d   = onpc_q;
      ovalid_d = ovalid_q;
      sinstr_d = sinstr_q;
      spc_d    = spc_q;
      svalid_d = svalid_q;
      case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            if (redirect) begin
               pc_d     = redirect_tgt;
               ovalid_d = 1'b0;
               svalid_d = 1'b0;
               if (req && !imem_ack) state_d = S_KILL;
            end else begin
               if (consume) begin
                  if (svalid_q) begin
                     oinstr_d = sinstr_q;
                     opc_d    = spc_q;
                     onpc_d   = spc_q + FOUR;
                     svalid_d = 1'b0;
                  end else begin
                     ovalid_d = 1'b0;
                  end
               end
               if (ack_acc) begin
                  pc_d = pc_q + FOUR;
                  if (!ovalid_q || (consume && !svalid_q)) begin
                     oinstr_d = imem_rdata;
                     opc_d    = addr_q;
                     onpc_d   = addr_q + FOUR;
                     ovalid_d = 1'b1;
                  end else begin
                     sinstr_d = imem_rdata;
                     spc_d    = addr_q;
                     svalid_d = 1'b1;
                  end
               end
            end
         end
         S_KILL: begin
            if (redirect) begin
               pc_d     = redirect_tgt;
               ovalid_d = 1'b0;
               svalid_d = 1'b0;
            end
            if (imem_ack) state_d = S_FETCH;
         end
         default: state_d = S_IDLE;
      endcase
      // A new transaction always starts from the PC about to be committed.
      addr_d = (state_d == S_KILL) ? addr_q : pc_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         pc_q     <= RESET_PC;
         addr_q   <= RESET_PC;
         oinstr_q <= '0;
         opc_q    <= '0;
         onpc_q   <= '0;
         ovalid_q <= 1'b0;
         sinstr_q <= '0;
         spc_q    <= '0;
         svalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         addr_q   <= addr_d;
         oinstr_q <= oinstr_d;
         opc_q    <= opc_d;
         onpc_q   <= onpc_d;
         ovalid_q <= ovalid_d;
         sinstr_q <= sinstr_d;
         spc_q    <= spc_d;
         svalid_q <= svalid_d;
      end
   end

   assign imem_req        = req;
   assign imem_addr       = addr_q;
   assign instr_reg_fetch = oinstr_q;
   assign pc_fetch        = opc_q;
   assign npc_fetch       = onpc_q;
   assign fetch_valid     = ovalid_q;
   assign state_dbg       = state_q;

endmodule
